// File: rtl/shield_meter_if.sv
// Shield-meter signal bundle shared by the game core, player control and HUD.
//   shield_btn     : shield button level, sampled on each shield tick
//   hit_req/ack    : 4-phase blocked-hit handshake (core drives req, meter acks)
//   shield         : current energy 0..15
//   shield_ok      : shielding currently allowed
//   shield_broken  : meter is in the lockout after depletion
//   bar            : HUD thermometer, LSB-first
// master = game core / control side, slave = the meter itself.
interface shield_meter_if;
  logic       shield_btn;
  logic       hit_req;
  logic       hit_ack;
  logic [3:0] shield;
  logic       shield_ok;
  logic       shield_broken;
  logic [7:0] bar;

  modport master (
    output shield_btn, hit_req,
    input  hit_ack, shield, shield_ok, shield_broken, bar
  );

  modport slave (
    input  shield_btn, hit_req,
    output hit_ack, shield, shield_ok, shield_broken, bar
  );
endinterface

// File: rtl/shield_meter.sv
// Shield-energy manager for one fighter, clocked on the slow shield tick.
// Holding the button drains energy. After release the meter waits
// REGEN_DELAY ticks and then regenerates. Running dry breaks the shield
// into a BREAK_LOCKOUT-tick lockout. Blocked hits arrive over a 4-phase
// req/ack and cost CHIP_DMG extra energy when they land on a draining tick.
// Ports:
//   slowed_shield_clk : slow shield tick, the only clock of this block
//   reset             : synchronous, active-low
//   bus               : shield_meter_if.slave (button, hit handshake, outputs)
module shield_meter #(
  parameter int MAX_SHIELD    = 15,
  parameter int DRAIN         = 1,
  parameter int REGEN         = 1,
  parameter int REGEN_DELAY   = 2,
  parameter int BREAK_LOCKOUT = 6,
  parameter int CHIP_DMG      = 3
) (
  input  logic             slowed_shield_clk,
  input  logic             reset,
  shield_meter_if.slave    bus
);

  typedef enum logic [1:0] {
    READY   = 2'd0,
    HOLDING = 2'd1,
    DELAY   = 2'd2,
    BROKEN  = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [3:0] shield, shield_next;
  logic [3:0] count, count_next;
  logic       hit_ack, hit_ack_next;

  logic       drain_tick;
  logic       new_hit;
  logic [4:0] sub;
  logic [4:0] regen_sum;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge slowed_shield_clk) begin
    if (!reset) begin
      state   <= READY;
      shield  <= 4'(MAX_SHIELD);
      count   <= 4'd0;
      hit_ack <= 1'b0;
    end else begin
      state   <= state_next;
      shield  <= shield_next;
      count   <= count_next;
      hit_ack <= hit_ack_next;
    end
  end

  assign drain_tick = bus.shield_btn && (state != BROKEN) && (shield != 4'd0);
  assign new_hit    = bus.hit_req && !hit_ack;

  // Both sums are widened to 5 bits so the compare/clamp sees the true value.
  assign sub       = 5'(DRAIN) + (new_hit ? 5'(CHIP_DMG) : 5'd0);
  assign regen_sum = {1'b0, shield} + 5'(REGEN);

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next  = state;
    shield_next = shield;
    count_next  = count;
    // The ack simply follows the request one tick later: it rises on a new
    // hit, stays up while req is held and drops on the first idle tick.
    hit_ack_next = bus.hit_req;

    if (drain_tick) begin
      if ({1'b0, shield} > sub) begin
        shield_next = shield - sub[3:0];
        state_next  = HOLDING;
      end else begin
        shield_next = 4'd0;
        state_next  = BROKEN;
        count_next  = 4'(BREAK_LOCKOUT);
      end
    end else begin
      unique case (state)
        READY: begin
          if (regen_sum > 5'(MAX_SHIELD)) shield_next = 4'(MAX_SHIELD);
          else                            shield_next = regen_sum[3:0];
        end
        HOLDING: begin
          if (REGEN_DELAY == 0) begin
            state_next = READY;
          end else begin
            state_next = DELAY;
            count_next = 4'(REGEN_DELAY);
          end
        end
        DELAY: begin
          count_next = count - 4'd1;
          if (count == 4'd1) state_next = READY;
        end
        BROKEN: begin
          shield_next = 4'd0;
          count_next  = count - 4'd1;
          if (count == 4'd1) state_next = READY;
        end
        default: state_next = READY;
      endcase
    end
  end

  // Thermometer with one segment per two energy units, rounded up.
  function automatic logic [7:0] bar_of(input logic [3:0] s);
    logic [4:0] n;
    logic [8:0] ones;
    n    = (5'(s) + 5'd1) >> 1;
    ones = (9'd1 << n) - 9'd1;
    return ones[7:0];
  endfunction

  assign bus.shield        = shield;
  assign bus.hit_ack       = hit_ack;
  assign bus.shield_ok     = (state != BROKEN) && (shield != 4'd0);
  assign bus.shield_broken = (state == BROKEN);
  assign bus.bar           = bar_of(shield);

endmodule

// File: tb/tb_shield_meter.sv
// Directed bench for shield_meter: each scenario task drives the button and
// hit handshake tick by tick and compares against hand-computed values.
module tb_shield_meter;

  logic slowed_shield_clk = 1'b0;
  logic reset;

  shield_meter_if bus ();

  shield_meter dut (
    .slowed_shield_clk (slowed_shield_clk),
    .reset             (reset),
    .bus               (bus.slave)
  );

  always #5 slowed_shield_clk = ~slowed_shield_clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Advance one shield tick and settle just after the edge.
  task automatic tick();
    @(posedge slowed_shield_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.shield_btn = 1'b0;
    bus.hit_req    = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.shield !== 4'd15) begin
      n_fails++; $display("FAIL reset_shield got=%0d exp=15", bus.shield);
    end
    n_checks++;
    if (bus.bar !== 8'hFF) begin
      n_fails++; $display("FAIL reset_bar got=%h exp=ff", bus.bar);
    end
    n_checks++;
    if (bus.shield_ok !== 1'b1 || bus.shield_broken !== 1'b0 || bus.hit_ack !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_flags got ok=%b broken=%b ack=%b exp ok=1 broken=0 ack=0",
               bus.shield_ok, bus.shield_broken, bus.hit_ack);
    end
  endtask

  task automatic test_drain_regen();
    int exp_hold [5] = '{14, 13, 12, 11, 10};
    // HOLDING->DELAY tick, two DELAY ticks (last leaves to READY), then regen.
    int exp_rel  [9] = '{10, 10, 10, 11, 12, 13, 14, 15, 15};
    do_reset();
    bus.shield_btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus.shield !== 4'(exp_hold[i])) begin
        n_fails++; $display("FAIL drain[%0d] got=%0d exp=%0d", i, bus.shield, exp_hold[i]);
      end
    end
    n_checks++;
    if (bus.bar !== 8'h1F) begin
      n_fails++; $display("FAIL bar_at_10 got=%h exp=1f", bus.bar);
    end
    bus.shield_btn = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++;
      if (bus.shield !== 4'(exp_rel[i]) || bus.shield_ok !== 1'b1) begin
        n_fails++;
        $display("FAIL regen[%0d] got=%0d ok=%b exp=%0d ok=1", i, bus.shield, bus.shield_ok, exp_rel[i]);
      end
    end
  endtask

  task automatic test_delay_press();
    int exp [6] = '{13, 12, 12, 12, 12, 13};
    do_reset();
    bus.shield_btn = 1'b1;
    tick(); tick();                       // 15 -> 14 -> 13
    bus.shield_btn = 1'b0;
    tick();                               // DELAY, 13
    n_checks++;
    if (bus.shield !== 4'd13) begin
      n_fails++; $display("FAIL delay_hold got=%0d exp=13", bus.shield);
    end
    bus.shield_btn = 1'b1;
    tick();                               // drain from DELAY, back to HOLDING
    bus.shield_btn = 1'b0;
    n_checks++;
    if (bus.shield !== 4'd12) begin
      n_fails++; $display("FAIL delay_press got=%0d exp=12", bus.shield);
    end
    // Full delay restarts: HOLDING->DELAY, DELAY, DELAY->READY, regen.
    for (int i = 2; i < 6; i++) begin
      tick();
      n_checks++;
      if (bus.shield !== 4'(exp[i])) begin
        n_fails++; $display("FAIL delay_restart[%0d] got=%0d exp=%0d", i, bus.shield, exp[i]);
      end
    end
  endtask

  task automatic test_break();
    do_reset();
    bus.shield_btn = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    n_checks++;
    if (bus.shield !== 4'd0 || bus.shield_broken !== 1'b1 || bus.shield_ok !== 1'b0 || bus.bar !== 8'h00) begin
      n_fails++;
      $display("FAIL break_entry got shield=%0d broken=%b ok=%b bar=%h exp 0/1/0/00",
               bus.shield, bus.shield_broken, bus.shield_ok, bus.bar);
    end
    // Button still held: five more ticks in BROKEN, the sixth leaves.
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus.shield !== 4'd0 || bus.shield_broken !== 1'b1) begin
        n_fails++;
        $display("FAIL lockout[%0d] got shield=%0d broken=%b exp 0/1", i, bus.shield, bus.shield_broken);
      end
    end
    tick();
    n_checks++;
    if (bus.shield !== 4'd0 || bus.shield_broken !== 1'b0 || bus.shield_ok !== 1'b0) begin
      n_fails++;
      $display("FAIL lockout_exit got shield=%0d broken=%b ok=%b exp 0/0/0",
               bus.shield, bus.shield_broken, bus.shield_ok);
    end
    bus.shield_btn = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (bus.shield !== 4'(i) || bus.shield_ok !== 1'b1) begin
        n_fails++; $display("FAIL post_break[%0d] got=%0d ok=%b exp=%0d ok=1", i, bus.shield, bus.shield_ok, i);
      end
    end
    n_checks++;
    if (bus.bar !== 8'h03) begin
      n_fails++; $display("FAIL bar_at_3 got=%h exp=03", bus.bar);
    end
  endtask

  task automatic test_chip_damage();
    do_reset();
    bus.shield_btn = 1'b1;
    for (int i = 0; i < 10; i++) tick();   // 15 -> 5
    bus.hit_req = 1'b1;
    tick();                                // 5 - 1 - 3 = 1
    n_checks++;
    if (bus.shield !== 4'd1 || bus.hit_ack !== 1'b1 || bus.shield_ok !== 1'b1) begin
      n_fails++;
      $display("FAIL chip_hit got shield=%0d ack=%b ok=%b exp 1/1/1", bus.shield, bus.hit_ack, bus.shield_ok);
    end
    tick();                                // same request, plain drain only
    n_checks++;
    if (bus.shield !== 4'd0 || bus.shield_broken !== 1'b1 || bus.hit_ack !== 1'b1) begin
      n_fails++;
      $display("FAIL chip_break got shield=%0d broken=%b ack=%b exp 0/1/1",
               bus.shield, bus.shield_broken, bus.hit_ack);
    end
    tick();
    n_checks++;
    if (bus.hit_ack !== 1'b1 || bus.shield_broken !== 1'b1) begin
      n_fails++; $display("FAIL ack_held got ack=%b broken=%b exp 1/1", bus.hit_ack, bus.shield_broken);
    end
    bus.hit_req = 1'b0;
    tick();
    n_checks++;
    if (bus.hit_ack !== 1'b0) begin
      n_fails++; $display("FAIL ack_drop got=%b exp=0", bus.hit_ack);
    end
    bus.shield_btn = 1'b0;
  endtask

  task automatic test_hit_no_drain();
    do_reset();
    bus.shield_btn = 1'b1;
    tick(); tick(); tick();                // 12
    bus.shield_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.shield !== 4'd12) begin
        n_fails++; $display("FAIL settle_12[%0d] got=%0d exp=12", i, bus.shield);
      end
    end
    bus.hit_req = 1'b1;
    tick();
    n_checks++;
    if (bus.shield !== 4'd13 || bus.hit_ack !== 1'b1) begin
      n_fails++; $display("FAIL ready_hit got shield=%0d ack=%b exp 13/1", bus.shield, bus.hit_ack);
    end
    bus.hit_req = 1'b0;
    tick();
    n_checks++;
    if (bus.shield !== 4'd14 || bus.hit_ack !== 1'b0) begin
      n_fails++; $display("FAIL ready_release got shield=%0d ack=%b exp 14/0", bus.shield, bus.hit_ack);
    end
  endtask

  task automatic test_reset_mid_break();
    do_reset();
    bus.shield_btn = 1'b1;
    for (int i = 0; i < 15; i++) tick();   // BROKEN, count 6
    tick(); tick();                        // count 4
    bus.hit_req = 1'b1;
    tick();                                // count 3, acked
    n_checks++;
    if (bus.shield_broken !== 1'b1 || bus.hit_ack !== 1'b1) begin
      n_fails++; $display("FAIL mid_break got broken=%b ack=%b exp 1/1", bus.shield_broken, bus.hit_ack);
    end
    reset = 1'b0;                          // request still pending during reset
    tick();
    reset = 1'b1;
    bus.hit_req    = 1'b0;
    bus.shield_btn = 1'b0;
    n_checks++;
    if (bus.shield !== 4'd15 || bus.shield_broken !== 1'b0 || bus.shield_ok !== 1'b1 || bus.hit_ack !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_override got shield=%0d broken=%b ok=%b ack=%b exp 15/0/1/0",
               bus.shield, bus.shield_broken, bus.shield_ok, bus.hit_ack);
    end
    tick();
    n_checks++;
    if (bus.shield !== 4'd15 || bus.shield_broken !== 1'b0) begin
      n_fails++; $display("FAIL after_reset got shield=%0d broken=%b exp 15/0", bus.shield, bus.shield_broken);
    end
  endtask

  initial begin
    reset          = 1'b0;
    bus.shield_btn = 1'b0;
    bus.hit_req    = 1'b0;
    #2;
    test_reset();
    test_drain_regen();
    test_delay_press();
    test_break();
    test_chip_damage();
    test_hit_no_drain();
    test_reset_mid_break();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
